systolic_ctrl: RTL

Sequencer for the 2x2 `systolic` array. It accepts a start command, fetches operand vectors from two synchronous-read memories and drives them into the array with the required one-cycle lane skew. It manages the array's clear and enable, then presents the four accumulated results through a valid/ready handshake. It sits between the operand buffers and the result writeback path.

---
 rtl/systolic_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_ctrl
// Description : Sequencer for the 2x2 systolic array. Accepts a start command,
//               streams operand vectors from two synchronous-read memories into
//               the array with a one-cycle lane skew, manages array clear and
//               enable, and returns the four accumulated results through a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_ctrl #(
    parameter int DATAWITH   = 16,
    parameter int ARRAY_SIZE = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int K_WIDTH    = 8,
    parameter int MAX_K      = 12
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [K_WIDTH-1:0]                       k_len,
    input  logic [ADDR_WIDTH-1:0]                    a_base,
    input  logic [ADDR_WIDTH-1:0]                    b_base,
    output logic                                     a_rd,
    output logic                                     b_rd,
    output logic [ADDR_WIDTH-1:0]                    a_addr,
    output logic [ADDR_WIDTH-1:0]                    b_addr,
    input  logic [ARRAY_SIZE*DATAWITH-1:0]           a_rdata,
    input  logic [ARRAY_SIZE*DATAWITH-1:0]           b_rdata,
    output logic                                     arr_rst_n,
    output logic                                     arr_en,
    output logic [ARRAY_SIZE*DATAWITH-1:0]           arr_data,
    output logic [ARRAY_SIZE*DATAWITH-1:0]           arr_weight,
    input  logic [ARRAY_SIZE*ARRAY_SIZE*DATAWITH-1:0] arr_result,
    output logic                                     res_valid,
    input  logic                                     res_ready,
    output logic [ARRAY_SIZE*ARRAY_SIZE*DATAWITH-1:0] res_data,
    output logic                                     busy,
    output logic                                     err
);

    localparam logic [K_WIDTH-1:0] C_MAX_K      = K_WIDTH'(MAX_K);
    localparam logic [K_WIDTH-1:0] C_DRAIN_LAST = K_WIDTH'(2);
    localparam logic [K_WIDTH-1:0] C_ONE        = K_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [K_WIDTH-1:0]      cnt_q, cnt_d;
    logic [K_WIDTH-1:0]      k_q;
    logic [ADDR_WIDTH-1:0]   a_base_q, b_base_q;
    logic                    k_ok, accept, reject, load_res, rd_en;
    logic                    err_q, arr_rst_n_q, rd_valid_q;
    logic [DATAWITH-1:0]     a_lane0_q, a_skew_q, a_lane1_q;
    logic [DATAWITH-1:0]     b_lane0_q, b_skew_q, b_lane1_q;
    logic [ARRAY_SIZE*ARRAY_SIZE*DATAWITH-1:0] res_data_q;

    // Longer runs would let the array's 4-bit enable counter wrap mid-accumulate.
    assign k_ok = (k_len != '0) && (k_len <= C_MAX_K);

    // State and phase counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, phase counting and per-state control outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        reject    = 1'b0;
        load_res  = 1'b0;
        rd_en     = 1'b0;
        arr_en    = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    if (k_ok) begin
                        accept  = 1'b1;
                        state_d = S_CLEAR;
                    end else begin
                        reject  = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                // Two extra cycles beyond the reads let the lane pipeline fill.
                arr_en = 1'b1;
                rd_en  = (cnt_q < k_q);
                if (cnt_q == k_q + C_ONE) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d   = cnt_q + C_ONE;
                end
            end
            S_DRAIN: begin
                arr_en = 1'b1;
                if (cnt_q == C_DRAIN_LAST) begin
                    load_res = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_HOLD;
                end else begin
                    cnt_d    = cnt_q + C_ONE;
                end
            end
            S_HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Command latch, reject pulse, array clear and result capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            k_q         <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            err_q       <= 1'b0;
            arr_rst_n_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            if (accept) begin
                k_q      <= k_len;
                a_base_q <= a_base;
                b_base_q <= b_base;
            end
            err_q       <= reject;
            arr_rst_n_q <= (state_d != S_CLEAR);
            if (load_res) begin
                res_data_q <= arr_result;
            end
        end
    end

    // Operand pipeline: lane 0 one register after read data, lane 1 one more
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            a_lane0_q  <= '0;
            a_skew_q   <= '0;
            a_lane1_q  <= '0;
            b_lane0_q  <= '0;
            b_skew_q   <= '0;
            b_lane1_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            a_lane0_q  <= rd_valid_q ? a_rdata[DATAWITH-1:0] : '0;
            a_skew_q   <= rd_valid_q ? a_rdata[2*DATAWITH-1:DATAWITH] : '0;
            a_lane1_q  <= a_skew_q;
            b_lane0_q  <= rd_valid_q ? b_rdata[DATAWITH-1:0] : '0;
            b_skew_q   <= rd_valid_q ? b_rdata[2*DATAWITH-1:DATAWITH] : '0;
            b_lane1_q  <= b_skew_q;
        end
    end

    assign a_rd       = rd_en;
    assign b_rd       = rd_en;
    assign a_addr     = rd_en ? (a_base_q + ADDR_WIDTH'(cnt_q)) : '0;
    assign b_addr     = rd_en ? (b_base_q + ADDR_WIDTH'(cnt_q)) : '0;
    assign arr_data   = {a_lane1_q, a_lane0_q};
    assign arr_weight = {b_lane1_q, b_lane0_q};
    assign arr_rst_n  = arr_rst_n_q;
    assign res_data   = res_data_q;
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;

endmodule
`default_nettype wire
